wt_mem_responder: RTL

- Memory-side responder for the write-through L1 cache request/return protocol; the far end of the L1 caches' memory ports.
- Accepts I$ fill requests and D$ load/store/AMO requests on two independent req/ack ports and round-robin arbitrates between them.
- Services each request from a local 64-bit-word backing store after a fixed latency and returns one return-valid pulse per request.
- Used as a fast L2/memory stand-in for cache-subsystem simulation and FPGA bring-up without an AXI fabric.

---
 rtl/wt_mem_responder_pkg.sv | 57 +++++
 rtl/wt_mem_amo_alu.sv | 52 +++++
 rtl/wt_mem_responder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wt_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wt_mem_responder_pkg
// Purpose  : Shared types and helpers for the write-through L1 memory
//            responder: request/return type encodings, AMO op codes,
//            responder FSM states and store byte-enable generation.
// Revision : 1.0 - initial release
// ============================================================================
package wt_mem_responder_pkg;

    // D$ request type as presented on the request port
    typedef enum logic [1:0] {
        REQ_LOAD  = 2'd0,
        REQ_STORE = 2'd1,
        REQ_AMO   = 2'd2,
        REQ_RSVD  = 2'd3
    } rsp_req_type_e;

    // D$ return type
    typedef enum logic [1:0] {
        RTRN_LOAD  = 2'd0,
        RTRN_STORE = 2'd1,
        RTRN_AMO   = 2'd2
    } rsp_rtrn_type_e;

    // Atomic operations; undefined codes fall back to swap
    typedef enum logic [2:0] {
        AMO_SWAP = 3'd0,
        AMO_ADD  = 3'd1,
        AMO_AND  = 3'd2,
        AMO_OR   = 3'd3,
        AMO_XOR  = 3'd4
    } amo_op_e;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rsp_state_e;

    // Byte enables for a store of 2**size bytes at byte offset 'offset'.
    // Sizes above a dword saturate to a full mask; the shifted result is
    // truncated to the 8 byte lanes of the word.
    function automatic logic [7:0] be_gen(input logic [2:0] size, input logic [2:0] offset);
        logic [7:0] mask;
        case (size)
            3'd0:    mask = 8'h01;
            3'd1:    mask = 8'h03;
            3'd2:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask << offset;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wt_mem_amo_alu.sv
`default_nettype none
// ============================================================================
// Module   : wt_mem_amo_alu
// Purpose  : Combinational AMO datapath. Produces the full 64-bit word to be
//            written back; 32-bit operations only modify the selected half.
// Revision : 1.0 - initial release
// ============================================================================
module wt_mem_amo_alu
    import wt_mem_responder_pkg::*;
(
    input  logic [63:0] old_data,
    input  logic [63:0] operand,
    input  logic [2:0]  op,
    input  logic [2:0]  size,
    input  logic        lane,
    output logic [63:0] new_data
);

    logic        is_word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;

    // Select operands by width, apply the op, merge the result into the word
    always_comb begin
        is_word  = (size == 3'd2);
        a        = old_data;
        b        = operand;
        if (is_word) begin
            a = {32'h0, (lane ? old_data[63:32] : old_data[31:0])};
            b = {32'h0, (lane ? operand[63:32]  : operand[31:0])};
        end
        case (amo_op_e'(op))
            AMO_ADD: r = a + b;
            AMO_AND: r = a & b;
            AMO_OR:  r = a | b;
            AMO_XOR: r = a ^ b;
            default: r = b;
        endcase
        new_data = r;
        if (is_word) begin
            new_data = old_data;
            if (lane) begin
                new_data[63:32] = r[31:0];
            end else begin
                new_data[31:0] = r[31:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wt_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : wt_mem_responder
// Purpose  : Memory-side responder for the write-through L1 request/return
//            protocol. Round-robin arbitrates the I$ and D$ request ports,
//            services one request at a time from a local 64-bit backing
//            store after a fixed latency and pulses one return per request.
// Revision : 1.0 - initial release
// ============================================================================
module wt_mem_responder
    import wt_mem_responder_pkg::*;
#(
    parameter int unsigned Depth     = 4096,
    parameter int unsigned LineWidth = 128,
    parameter int unsigned Latency   = 4,
    parameter int unsigned PLen      = 56,
    parameter int unsigned TidWidth  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output logic                 busy_o,
    input  logic                 icache_data_req_i,
    output logic                 icache_data_ack_o,
    input  logic [PLen-1:0]      icache_paddr_i,
    input  logic [TidWidth-1:0]  icache_tid_i,
    output logic                 icache_rtrn_vld_o,
    output logic [LineWidth-1:0] icache_rtrn_data_o,
    output logic [TidWidth-1:0]  icache_rtrn_tid_o,
    input  logic                 dcache_data_req_i,
    output logic                 dcache_data_ack_o,
    input  logic [1:0]           dcache_rtype_i,
    input  logic [2:0]           dcache_size_i,
    input  logic                 dcache_nc_i,
    input  logic [2:0]           dcache_amo_op_i,
    input  logic [PLen-1:0]      dcache_paddr_i,
    input  logic [63:0]          dcache_data_i,
    input  logic [TidWidth-1:0]  dcache_tid_i,
    output logic                 dcache_rtrn_vld_o,
    output logic [1:0]           dcache_rtrn_type_o,
    output logic [LineWidth-1:0] dcache_rtrn_data_o,
    output logic [TidWidth-1:0]  dcache_rtrn_tid_o
);

    localparam int IW  = $clog2(Depth);
    localparam int WPL = LineWidth / 64;
    localparam int CW  = (Latency > 1) ? $clog2(Latency) : 1;

    rsp_state_e state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    // Round-robin: set when the D$ should win the next tie
    logic prio_d;
    logic grant_i, grant_d, accept;

    // Captured request
    logic                req_d;
    logic [1:0]          rtype;
    logic [2:0]          size;
    logic                nc;
    logic [2:0]          amo_op;
    logic [PLen-1:0]     paddr;
    logic [63:0]         wdata;
    logic [TidWidth-1:0] tid;

    // Held return values, shown while the return-valid is low
    logic [LineWidth-1:0] i_data_hold, d_data_hold;
    logic [TidWidth-1:0]  i_tid_hold, d_tid_hold;
    logic [1:0]           d_type_hold;

    logic [63:0] mem [Depth];

    logic [IW-1:0]        word_idx, line_base;
    logic [63:0]          word;
    logic [LineWidth-1:0] line_rd;
    logic [63:0]          amo_new, amo_ret;
    logic [7:0]           be;
    logic [LineWidth-1:0] resp_data;
    logic [1:0]           resp_type;
    logic                 in_resp;
    logic                 unused_bits;

    assign unused_bits = ^paddr[PLen-1:IW+3];

    // Arbitration: a lone requester wins, ties go to the port not granted last
    always_comb begin
        grant_i           = icache_data_req_i && (!dcache_data_req_i || !prio_d);
        grant_d           = dcache_data_req_i && (!icache_data_req_i || prio_d);
        accept            = (state == ST_IDLE) && (grant_i || grant_d);
        icache_data_ack_o = rst_ni && (state == ST_IDLE) && grant_i;
        dcache_data_ack_o = rst_ni && (state == ST_IDLE) && grant_d;
    end

    // FSM next-state and latency counter
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    cnt_next   = CW'(Latency - 1);
                    state_next = (Latency == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state, counter and arbitration pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            prio_d <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                prio_d <= grant_i;
            end
        end
    end

    // Capture the granted request on accept; I$ fills are cacheable line loads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_d  <= 1'b0;
            rtype  <= '0;
            size   <= '0;
            nc     <= 1'b0;
            amo_op <= '0;
            paddr  <= '0;
            wdata  <= '0;
            tid    <= '0;
        end else if (accept) begin
            req_d <= grant_d;
            if (grant_d) begin
                rtype  <= dcache_rtype_i;
                size   <= dcache_size_i;
                nc     <= dcache_nc_i;
                amo_op <= dcache_amo_op_i;
                paddr  <= dcache_paddr_i;
                wdata  <= dcache_data_i;
                tid    <= dcache_tid_i;
            end else begin
                rtype  <= REQ_LOAD;
                size   <= 3'd3;
                nc     <= 1'b0;
                amo_op <= '0;
                paddr  <= icache_paddr_i;
                wdata  <= '0;
                tid    <= icache_tid_i;
            end
        end
    end

    assign word_idx  = paddr[IW+2:3];
    assign line_base = word_idx & ~IW'(WPL - 1);
    assign word      = mem[word_idx];
    assign be        = be_gen(size, paddr[2:0]);
    assign in_resp   = (state == ST_RESP);

    wt_mem_amo_alu u_amo_alu (
        .old_data (word),
        .operand  (wdata),
        .op       (amo_op),
        .size     (size),
        .lane     (paddr[2]),
        .new_data (amo_new)
    );

    // Response data: line read, replicated word, store ack or AMO old value
    always_comb begin
        line_rd = '0;
        for (int k = 0; k < WPL; k++) begin
            line_rd[64*k +: 64] = mem[line_base | IW'(k)];
        end
        amo_ret = word;
        if (size == 3'd2) begin
            amo_ret = paddr[2] ? {word[63:32], 32'h0} : {32'h0, word[31:0]};
        end
        case (rtype)
            REQ_STORE: begin
                resp_data = '0;
                resp_type = RTRN_STORE;
            end
            REQ_AMO: begin
                resp_data = LineWidth'(amo_ret);
                resp_type = RTRN_AMO;
            end
            default: begin
                resp_data = nc ? {WPL{word}} : line_rd;
                resp_type = RTRN_LOAD;
            end
        endcase
    end

    // Backing-store writes happen only in the response cycle
    always_ff @(posedge clk_i) begin
        if (in_resp && req_d) begin
            if (rtype == REQ_STORE) begin
                for (int b = 0; b < 8; b++) begin
                    if (be[b]) begin
                        mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else if (rtype == REQ_AMO) begin
                mem[word_idx] <= amo_new;
            end
        end
    end

    // Hold the last returned values for display while no return is active
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            i_data_hold <= '0;
            i_tid_hold  <= '0;
            d_data_hold <= '0;
            d_tid_hold  <= '0;
            d_type_hold <= '0;
        end else if (in_resp) begin
            if (req_d) begin
                d_data_hold <= resp_data;
                d_tid_hold  <= tid;
                d_type_hold <= resp_type;
            end else begin
                i_data_hold <= resp_data;
                i_tid_hold  <= tid;
            end
        end
    end

    assign busy_o             = (state != ST_IDLE);
    assign icache_rtrn_vld_o  = in_resp && !req_d;
    assign dcache_rtrn_vld_o  = in_resp && req_d;
    assign icache_rtrn_data_o = icache_rtrn_vld_o ? resp_data : i_data_hold;
    assign icache_rtrn_tid_o  = icache_rtrn_vld_o ? tid : i_tid_hold;
    assign dcache_rtrn_data_o = dcache_rtrn_vld_o ? resp_data : d_data_hold;
    assign dcache_rtrn_tid_o  = dcache_rtrn_vld_o ? tid : d_tid_hold;
    assign dcache_rtrn_type_o = dcache_rtrn_vld_o ? resp_type : d_type_hold;

endmodule
`default_nettype wire
